// File: rtl/rr_mux_pkg.sv
// Shared types and helpers for the round-robin 16:1 mux scheduler.
// Latency: none (declarations only).
// Backpressure: n/a.
package rr_mux_pkg;

   localparam int N     = 16;
   localparam int SEL_W = 4;

   typedef enum logic {
      IDLE = 1'b0,
      GNT  = 1'b1
   } state_t;

   // One-hot vector with a single bit set at position idx.
   function automatic logic [N-1:0] onehot16(input logic [SEL_W-1:0] idx);
      onehot16 = {{(N-1){1'b0}}, 1'b1} << idx;
   endfunction

endpackage

// File: rtl/rr_pick16.sv
// Wrap-around first-one finder over a 16-bit vector, scanning from a start index.
// Latency: purely combinational.
// Backpressure: n/a; found=0 when the vector is empty.
module rr_pick16
   import rr_mux_pkg::*;
(
   input  logic [N-1:0]     vec,
   input  logic [SEL_W-1:0] start,
   output logic [SEL_W-1:0] idx,
   output logic             found
);

   logic [SEL_W-1:0] pos;

   // Scan from the far end back toward start so the nearest set bit after start wins.
   always_comb begin
      idx   = '0;
      found = 1'b0;
      pos   = '0;
      for (int k = N - 1; k >= 0; k--) begin
         pos = start + SEL_W'(k);
         if (vec[pos]) begin
            idx   = pos;
            found = 1'b1;
         end
      end
   end

endmodule

// File: rtl/rr_mux_sched.sv
// Round-robin scheduler owning the select of a shared 16:1 single-bit data mux.
// Latency: grant 1 cycle after req sampled high; back-to-back regrant on release with no idle cycle.
// Backpressure: a grant is held until done[sel], req[sel] low, or MAX_HOLD cycles (forced, tmo pulse).
module rr_mux_sched
   import rr_mux_pkg::*;
#(
   parameter int MAX_HOLD = 8,
   parameter int HOLD_W   = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [N-1:0]     req,
   input  logic [N-1:0]     done,
   input  logic [N-1:0]     in,
   output logic [N-1:0]     gnt,
   output logic [SEL_W-1:0] sel,
   output logic             busy,
   output logic             y,
   output logic             tmo
);

   state_t              state, state_n;
   logic [N-1:0]        gnt_n;
   logic [SEL_W-1:0]    sel_n;
   logic                busy_n;
   logic                tmo_n;
   logic [SEL_W-1:0]    ptr, ptr_n;
   logic [HOLD_W-1:0]   hold_cnt, hold_n;

   logic [SEL_W-1:0]    idle_idx, nxt_idx;
   logic                idle_found, nxt_found;
   logic                at_limit, holder_done, holder_req, rel;

   // Fresh search from IDLE starts just past the last granted index.
   rr_pick16 u_pick_idle (
      .vec   (req),
      .start (ptr + SEL_W'(1)),
      .idx   (idle_idx),
      .found (idle_found)
   );

   // Regrant search excludes the current holder so it cannot win twice in a row.
   rr_pick16 u_pick_next (
      .vec   (req & ~onehot16(sel)),
      .start (sel + SEL_W'(1)),
      .idx   (nxt_idx),
      .found (nxt_found)
   );

   assign holder_done = done[sel];
   assign holder_req  = req[sel];
   assign at_limit    = (hold_cnt == HOLD_W'(MAX_HOLD - 1));
   assign rel         = holder_done | ~holder_req | at_limit;

   // State and registered outputs; reset drops the grant at once and rewinds the pointer.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         gnt      <= '0;
         sel      <= '0;
         busy     <= 1'b0;
         tmo      <= 1'b0;
         ptr      <= SEL_W'(N - 1);
         hold_cnt <= '0;
      end else begin
         state    <= state_n;
         gnt      <= gnt_n;
         sel      <= sel_n;
         busy     <= busy_n;
         tmo      <= tmo_n;
         ptr      <= ptr_n;
         hold_cnt <= hold_n;
      end
   end

   // Next-state and next-output decisions for the grant FSM.
   always_comb begin
      state_n = state;
      gnt_n   = gnt;
      sel_n   = sel;
      busy_n  = busy;
      tmo_n   = 1'b0;
      ptr_n   = ptr;
      hold_n  = hold_cnt;
      case (state)
         IDLE: begin
            gnt_n  = '0;
            busy_n = 1'b0;
            if (idle_found) begin
               sel_n   = idle_idx;
               gnt_n   = onehot16(idle_idx);
               busy_n  = 1'b1;
               ptr_n   = idle_idx;
               hold_n  = '0;
               state_n = GNT;
            end
         end
         GNT: begin
            if (rel) begin
               // Only a release forced purely by the hold limit counts as a timeout.
               tmo_n = at_limit & ~holder_done & holder_req;
               if (nxt_found) begin
                  sel_n  = nxt_idx;
                  gnt_n  = onehot16(nxt_idx);
                  ptr_n  = nxt_idx;
                  hold_n = '0;
               end else begin
                  gnt_n   = '0;
                  busy_n  = 1'b0;
                  hold_n  = '0;
                  state_n = IDLE;
               end
            end else begin
               hold_n = hold_cnt + HOLD_W'(1);
            end
         end
         default: begin
            state_n = IDLE;
            gnt_n   = '0;
            busy_n  = 1'b0;
         end
      endcase
   end

   // Shared data mux: the selected requester's bit, forced low whenever nothing is granted.
   assign y = busy & in[sel];

endmodule

// File: tb/tb_rr_mux_sched.sv
// Directed bench for rr_mux_sched with hand-computed expectations per scenario.
// Latency: checks sampled 2 time units after each rising edge.
// Backpressure: done/req driven directly by the scenario tasks.
module tb_rr_mux_sched;

   logic        clk;
   logic        rst;
   logic [15:0] req;
   logic [15:0] done;
   logic [15:0] in;
   logic [15:0] gnt;
   logic [3:0]  sel;
   logic        busy;
   logic        y;
   logic        tmo;

   int total  = 0;
   int passed = 0;

   rr_mux_sched #(.MAX_HOLD(8), .HOLD_W(8)) dut (
      .clk  (clk),
      .rst  (rst),
      .req  (req),
      .done (done),
      .in   (in),
      .gnt  (gnt),
      .sel  (sel),
      .busy (busy),
      .y    (y),
      .tmo  (tmo)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic do_reset();
      rst  = 1'b1;
      req  = '0;
      done = '0;
      in   = '0;
      @(posedge clk);
      #2;
      rst = 1'b0;
   endtask

   task automatic test_reset();
      rst  = 1'b1;
      req  = 16'hFFFF;
      done = '0;
      in   = 16'hFFFF;
      @(posedge clk);
      #2;
      total++; if (gnt !== 16'h0000) $display("FAIL reset_gnt: got %h want %h", gnt, 16'h0000); else passed++;
      total++; if (sel !== 4'd0) $display("FAIL reset_sel: got %0d want 0", sel); else passed++;
      total++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else passed++;
      total++; if (tmo !== 1'b0) $display("FAIL reset_tmo: got %b want 0", tmo); else passed++;
      total++; if (y !== 1'b0) $display("FAIL reset_y: got %b want 0", y); else passed++;
      rst = 1'b0;
      req = '0;
      in  = '0;
   endtask

   task automatic test_single();
      do_reset();
      req = 16'h0001;
      tick();
      total++; if (gnt !== 16'h0001) $display("FAIL single_gnt: got %h want %h", gnt, 16'h0001); else passed++;
      total++; if (sel !== 4'd0) $display("FAIL single_sel: got %0d want 0", sel); else passed++;
      total++; if (busy !== 1'b1) $display("FAIL single_busy: got %b want 1", busy); else passed++;
      in = 16'h0001;
      #1;
      total++; if (y !== 1'b1) $display("FAIL single_y: got %b want 1", y); else passed++;
      in = 16'hFFFE;
      #1;
      total++; if (y !== 1'b0) $display("FAIL single_y_low: got %b want 0", y); else passed++;
      done = 16'h0001;
      tick();
      done = '0;
      req  = '0;
      total++; if (gnt !== 16'h0000) $display("FAIL single_rel_gnt: got %h want %h", gnt, 16'h0000); else passed++;
      total++; if (busy !== 1'b0) $display("FAIL single_rel_busy: got %b want 0", busy); else passed++;
      total++; if (tmo !== 1'b0) $display("FAIL single_rel_tmo: got %b want 0", tmo); else passed++;
      in = 16'hFFFF;
      #1;
      total++; if (y !== 1'b0) $display("FAIL idle_y: got %b want 0", y); else passed++;
   endtask

   task automatic test_rr_sweep();
      logic [15:0] data;
      logic [15:0] exp_gnt;
      int j;
      data = 16'hA5C3;
      do_reset();
      req  = 16'hFFFF;
      done = 16'hFFFF;
      in   = data;
      for (int i = 0; i < 17; i++) begin
         tick();
         j = i % 16;
         exp_gnt = 16'h0001 << j;
         total++; if (sel !== 4'(j)) $display("FAIL sweep_sel[%0d]: got %0d want %0d", i, sel, j); else passed++;
         total++; if (gnt !== exp_gnt) $display("FAIL sweep_gnt[%0d]: got %h want %h", i, gnt, exp_gnt); else passed++;
         total++; if (y !== data[j]) $display("FAIL sweep_y[%0d]: got %b want %b", i, y, data[j]); else passed++;
         total++; if (busy !== 1'b1) $display("FAIL sweep_busy[%0d]: got %b want 1", i, busy); else passed++;
      end
      req  = '0;
      done = '0;
   endtask

   task automatic test_timeout();
      do_reset();
      req = 16'h8001;
      tick();
      total++; if (gnt !== 16'h0001) $display("FAIL tmo_first_gnt: got %h want %h", gnt, 16'h0001); else passed++;
      for (int k = 1; k < 8; k++) begin
         tick();
         total++; if (gnt !== 16'h0001 || tmo !== 1'b0) $display("FAIL tmo_hold0[%0d]: got gnt=%h tmo=%b want gnt=0001 tmo=0", k, gnt, tmo); else passed++;
      end
      tick();
      total++; if (gnt !== 16'h8000) $display("FAIL tmo_switch15_gnt: got %h want %h", gnt, 16'h8000); else passed++;
      total++; if (tmo !== 1'b1) $display("FAIL tmo_switch15_pulse: got %b want 1", tmo); else passed++;
      for (int k = 1; k < 8; k++) begin
         tick();
         total++; if (gnt !== 16'h8000 || tmo !== 1'b0) $display("FAIL tmo_hold15[%0d]: got gnt=%h tmo=%b want gnt=8000 tmo=0", k, gnt, tmo); else passed++;
      end
      tick();
      total++; if (gnt !== 16'h0001) $display("FAIL tmo_switch0_gnt: got %h want %h", gnt, 16'h0001); else passed++;
      total++; if (tmo !== 1'b1) $display("FAIL tmo_switch0_pulse: got %b want 1", tmo); else passed++;
      tick();
      total++; if (tmo !== 1'b0) $display("FAIL tmo_one_cycle: got %b want 0", tmo); else passed++;
      req = '0;
   endtask

   task automatic test_req_drop();
      do_reset();
      req = 16'h0220;
      tick();
      total++; if (sel !== 4'd5) $display("FAIL drop_first_sel: got %0d want 5", sel); else passed++;
      req = 16'h0200;
      tick();
      total++; if (sel !== 4'd9) $display("FAIL drop_sel: got %0d want 9", sel); else passed++;
      total++; if (gnt !== 16'h0200) $display("FAIL drop_gnt: got %h want %h", gnt, 16'h0200); else passed++;
      total++; if (tmo !== 1'b0) $display("FAIL drop_tmo: got %b want 0", tmo); else passed++;
      req = '0;
   endtask

   task automatic test_reset_mid();
      do_reset();
      req = 16'h0080;
      in  = 16'h0080;
      tick();
      total++; if (sel !== 4'd7) $display("FAIL mid_pre_sel: got %0d want 7", sel); else passed++;
      total++; if (y !== 1'b1) $display("FAIL mid_pre_y: got %b want 1", y); else passed++;
      rst = 1'b1;
      #1;
      total++; if (gnt !== 16'h0000) $display("FAIL mid_gnt: got %h want %h", gnt, 16'h0000); else passed++;
      total++; if (busy !== 1'b0) $display("FAIL mid_busy: got %b want 0", busy); else passed++;
      total++; if (y !== 1'b0) $display("FAIL mid_y: got %b want 0", y); else passed++;
      // Bit 8 also requested: a pointer left at 7 would pick 8, a rewound one picks 7.
      req = 16'h0180;
      @(negedge clk);
      rst = 1'b0;
      tick();
      total++; if (sel !== 4'd7) $display("FAIL mid_after_sel: got %0d want 7", sel); else passed++;
      total++; if (gnt !== 16'h0080) $display("FAIL mid_after_gnt: got %h want %h", gnt, 16'h0080); else passed++;
      req = '0;
   endtask

   task automatic test_nonholder_done();
      do_reset();
      req  = 16'h0008;
      done = 16'h0010;
      tick();
      total++; if (gnt !== 16'h0008) $display("FAIL nh_first_gnt: got %h want %h", gnt, 16'h0008); else passed++;
      for (int k = 1; k < 8; k++) begin
         tick();
         total++; if (gnt !== 16'h0008 || tmo !== 1'b0) $display("FAIL nh_hold[%0d]: got gnt=%h tmo=%b want gnt=0008 tmo=0", k, gnt, tmo); else passed++;
      end
      tick();
      total++; if (gnt !== 16'h0000) $display("FAIL nh_tmo_gnt: got %h want %h", gnt, 16'h0000); else passed++;
      total++; if (busy !== 1'b0) $display("FAIL nh_tmo_busy: got %b want 0", busy); else passed++;
      total++; if (tmo !== 1'b1) $display("FAIL nh_tmo_pulse: got %b want 1", tmo); else passed++;
      total++; if (sel !== 4'd3) $display("FAIL nh_idle_sel: got %0d want 3", sel); else passed++;
      // done[3] while idle must not block the regrant.
      done = 16'h0008;
      tick();
      total++; if (gnt !== 16'h0008) $display("FAIL nh_regrant: got %h want %h", gnt, 16'h0008); else passed++;
      tick();
      total++; if (gnt !== 16'h0000) $display("FAIL nh_done_rel_gnt: got %h want %h", gnt, 16'h0000); else passed++;
      total++; if (tmo !== 1'b0) $display("FAIL nh_done_rel_tmo: got %b want 0", tmo); else passed++;
      req  = '0;
      done = '0;
   endtask

   initial begin
      rst  = 1'b1;
      req  = '0;
      done = '0;
      in   = '0;
      test_reset();
      test_single();
      test_rr_sweep();
      test_timeout();
      test_req_drop();
      test_reset_mid();
      test_nonholder_done();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/rr_mux_sched.md
Name: rr_mux_sched

Overview:
- Round-robin scheduler that shares one 16:1 single-bit data mux among 16 requesters.
- Arbitrates the req vector, registers the 4-bit select and a one-hot grant, and holds the grant until release or timeout.
- Returns the selected data bit, gated by the grant.
- Sits in front of the 16:1 mux datapath, so the mux select is never driven directly by requesters.

Parameters:
- N, 16, number of requesters. Fixed at 16; the select is 4 bits.
- MAX_HOLD, 8, maximum grant length in cycles before forced release. Legal range 1..255.
- HOLD_W, 8, width of the hold counter. Must satisfy 2^HOLD_W > MAX_HOLD.

Ports:
- clk  in  1  single system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- req  in  16  request per requester. Level: the requester holds it high until granted and serviced.
- done  in  16  per-requester release pulse. Only done[sel] is honoured while granted.
- in  in  16  data bit per requester, i.e. the mux data inputs.
- gnt  out  16  registered one-hot grant. All zero when idle.
- sel  out  4  registered mux select, equal to the index of the grant bit.
- busy  out  1  registered; high while in GNT.
- y  out  1  combinational; in[sel] when busy, else 0.
- tmo  out  1  registered one-cycle pulse when a grant is force-released by timeout.

Behaviour:
- Reset (asynchronous, immediate, any state):
  - state=IDLE, gnt=0, sel=0, busy=0, tmo=0.
  - ptr=15, so the first search starts at index 0.
  - hold_cnt=0.
  - y is 0 while rst is high.
- Search function pick(vec, start):
  - Scans indices start, start+1, ..., wrapping mod 16.
  - Returns the first index i with vec[i]=1, plus a found flag.
  - Purely combinational.
- State IDLE:
  - busy=0, gnt=0.
  - If |req at edge t: idx=pick(req, ptr+1). At edge t the block loads sel=idx, gnt=1<<idx, busy=1, ptr=idx, hold_cnt=0, and goes to GNT.
  - Grant latency is 1 cycle from req sampled high.
  - If req=0, stay in IDLE.
- State GNT, release condition rel:
  - rel = done[sel] OR !req[sel] OR (hold_cnt == MAX_HOLD-1).
  - Timeout counts only if neither of the other two terms is true; then tmo=1 for the following cycle.
- State GNT, no release: hold_cnt increments and the grant is held.
- State GNT, on release edge:
  - Compute nxt=pick(req & ~(1<<sel), sel+1).
  - If found: back-to-back grant with no idle cycle. sel=nxt, gnt=1<<nxt, ptr=nxt, hold_cnt=0, stay in GNT.
  - Else: go to IDLE, gnt=0, busy=0. sel keeps its last value.
- Fairness:
  - The current holder is excluded from the immediate regrant.
  - A requester waits at most 15 grants, i.e. at most 15*MAX_HOLD cycles plus switch cycles.
- Other rules:
  - done bits other than done[sel] are ignored.
  - done[sel] asserted in IDLE is ignored.
  - A requester re-raising req after release is eligible again only in round-robin order.
  - sel and gnt always change on the same edge; gnt is one-hot or zero, never multi-hot.
  - hold_cnt never exceeds MAX_HOLD-1, and no wrap is possible.
  - Reset mid-grant drops gnt and busy immediately, and ptr returns to 15.

Decomposition:
- Shared package rr_mux_pkg holds:
  - the state encoding (IDLE=1'b0, GNT=1'b1);
  - constants N=16 and SEL_W=4;
  - the function onehot16(idx).
- One sub-module, rr_pick16: combinational wrap-around first-one finder.
  - Inputs: vec[15:0], start[3:0].
  - Outputs: idx[3:0], found.
  - Instantiated once for the IDLE search and once for the GNT search.
- The data mux is the existing 16:1 mux block, instantiated with sel and gated by busy.

Test Plan:
- Reset then req=16'h0001: gnt=16'h0001, sel=0, busy=1 one edge later. Then in[0]=1 gives y=1, and done[0] pulse gives gnt=0, busy=0 next edge.
- req=16'hFFFF, done pulsed every cycle: grants appear in order 0,1,2,...,15,0 on consecutive edges with no idle gap. y tracks in[sel].
- req=16'h8001 held, no done, MAX_HOLD=8: gnt 0x0001 for 8 cycles, tmo pulse, then 0x8000 for 8 cycles, tmo, then 0x0001.
- Grant on index 5, req[5] drops while req[9] is high: next edge gives sel=9, gnt=16'h0200, and no tmo.
- rst asserted mid-GNT (sel=7): gnt=0, busy=0, y=0 immediately. After release with req=16'h0080, the grant goes to 7 (search from 0).
- Grant on 3 with done=16'h0010 (a non-holder pulse): grant unchanged, hold_cnt continues, and release happens only via done[3], req[3] low or timeout.
